// File: rtl/eth_uc_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// eth_uc_mem_responder_pkg
//
// Shared definitions for the uncached BedRock memory responder that answers
// the Ethernet controller's io_cmd traffic:
//   - processor configuration constants (physical address width, LCE id
//     width, associativity, dword width)
//   - BedRock memory message types, payload and header layouts
//   - responder FSM state enum
//   - size-to-byte-mask helper
//   - dword replication helper, also used by the controller's response path
// ----------------------------------------------------------------------------
package eth_uc_mem_responder_pkg;

    // Default processor configuration
    localparam int paddr_width_p  = 40;
    localparam int lce_id_width_p = 4;
    localparam int lce_assoc_p    = 8;
    localparam int dword_width_gp = 64;

    // BedRock memory message types
    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bedrock_mem_type_e;

    // Message size is log2 of the byte count: 0 -> 1B ... 3 -> 8B, 7 -> 128B
    localparam logic [2:0] e_bedrock_msg_size_1 = 3'd0;
    localparam logic [2:0] e_bedrock_msg_size_2 = 3'd1;
    localparam logic [2:0] e_bedrock_msg_size_4 = 3'd2;
    localparam logic [2:0] e_bedrock_msg_size_8 = 3'd3;

    typedef struct packed {
        logic [lce_id_width_p-1:0]      lce_id;
        logic [$clog2(lce_assoc_p)-1:0] way_id;
    } bedrock_mem_payload_s;

    typedef struct packed {
        bedrock_mem_payload_s     payload;
        logic [2:0]               size;
        logic [paddr_width_p-1:0] addr;
        logic [3:0]               subop;
        logic [3:0]               msg_type;
    } bedrock_mem_header_s;

    localparam int xce_mem_msg_header_width_lp = $bits(bedrock_mem_header_s);

    typedef enum logic [1:0] {
        e_ready  = 2'd0,
        e_access = 2'd1,
        e_resp   = 2'd2
    } eth_uc_responder_state_e;

    // Byte-enable mask for the low 2^size bytes of a dword. Sizes wider than
    // a dword saturate to a full mask; callers reject them separately.
    function automatic logic [7:0] size_to_byte_mask(input logic [2:0] size);
        logic [7:0] mask;
        case (size)
            3'd0:    mask = 8'h01;
            3'd1:    mask = 8'h03;
            3'd2:    mask = 8'h0f;
            default: mask = 8'hff;
        endcase
        return mask;
    endfunction

    // Replicate the low 2^size bytes of data across the full dword.
    function automatic logic [dword_width_gp-1:0] replicate_dword(
        input logic [dword_width_gp-1:0] data,
        input logic [2:0]                size
    );
        logic [dword_width_gp-1:0] rep;
        case (size)
            3'd0:    rep = {8{data[7:0]}};
            3'd1:    rep = {4{data[15:0]}};
            3'd2:    rep = {2{data[31:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/eth_uc_mem_responder_ram.sv
// ----------------------------------------------------------------------------
// bsg_mem_1rw_sync_mask_write_byte
//
// Single-port synchronous RAM with per-byte write enables. Reads return the
// addressed word on the clock edge after v_i & ~w_i; data_o holds its value
// until the next read. Contents are never cleared.
//
// Ports:
//   clk_i        : clock
//   v_i          : access enable
//   w_i          : 1 = write, 0 = read
//   addr_i       : word index
//   data_i       : write data
//   write_mask_i : one enable bit per byte of data_i
//   data_o       : registered read data
// ----------------------------------------------------------------------------
module bsg_mem_1rw_sync_mask_write_byte #(
    parameter int data_width_p = 64,
    parameter int els_p        = 8
) (
    input  logic                       clk_i,
    input  logic                       v_i,
    input  logic                       w_i,
    input  logic [$clog2(els_p)-1:0]   addr_i,
    input  logic [data_width_p-1:0]    data_i,
    input  logic [data_width_p/8-1:0]  write_mask_i,
    output logic [data_width_p-1:0]    data_o
);

    localparam int mask_width_lp = data_width_p / 8;

    logic [data_width_p-1:0] r_mem [els_p];
    logic [data_width_p-1:0] r_data;

    always_ff @(posedge clk_i) begin
        if (v_i && w_i) begin
            for (int b = 0; b < mask_width_lp; b++) begin
                if (write_mask_i[b]) begin
                    r_mem[addr_i][8*b +: 8] <= data_i[8*b +: 8];
                end
            end
        end
        if (v_i && !w_i) begin
            r_data <= r_mem[addr_i];
        end
    end

    assign data_o = r_data;

endmodule

// File: rtl/eth_uc_mem_responder.sv
// ----------------------------------------------------------------------------
// eth_uc_mem_responder
//
// Responder end of the uncached BedRock memory interface driven by the
// Ethernet controller. Accepts uc_rd / uc_wr commands into a small
// dword-addressed scratch RAM and returns exactly one response per command.
// Illegal commands (wrong type, out of range, misaligned, wider than a
// dword) are still answered, with zero data, and counted.
//
// Ports:
//   clk_i                : clock
//   reset_i              : synchronous active-high reset
//   mem_cmd_header_i     : command header (msg_type, subop, addr, size, payload)
//   mem_cmd_data_i       : write data, valid in the low 2^size bytes
//   mem_cmd_v_i          : command valid
//   mem_cmd_ready_and_o  : command ready (transfer on v & ready)
//   mem_resp_header_o    : response header (echo of the command header)
//   mem_resp_data_o      : read data replicated across the dword, else 0
//   mem_resp_v_o         : response valid
//   mem_resp_ready_and_i : response ready
//   err_count_o          : saturating count of rejected commands
//
// Timing: accept at cycle t, response valid at t+2, one command in flight.
// ----------------------------------------------------------------------------
module eth_uc_mem_responder
    import eth_uc_mem_responder_pkg::*;
#(
    parameter logic [paddr_width_p-1:0] base_addr_p = 40'h0080_3000_00,
    parameter int                       els_p       = 8
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,

    input  logic [xce_mem_msg_header_width_lp-1:0] mem_cmd_header_i,
    input  logic [dword_width_gp-1:0]              mem_cmd_data_i,
    input  logic                                   mem_cmd_v_i,
    output logic                                   mem_cmd_ready_and_o,

    output logic [xce_mem_msg_header_width_lp-1:0] mem_resp_header_o,
    output logic [dword_width_gp-1:0]              mem_resp_data_o,
    output logic                                   mem_resp_v_o,
    input  logic                                   mem_resp_ready_and_i,

    output logic [7:0]                             err_count_o
);

    localparam int lg_els_lp = $clog2(els_p);
    localparam logic [paddr_width_p-1:0] end_addr_lp =
        base_addr_p + paddr_width_p'(8 * els_p);

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    bedrock_mem_header_s       w_cmd_hdr;
    logic                      w_cmd_fire;
    logic                      w_is_rd;
    logic                      w_is_wr;
    logic                      w_in_range;
    logic                      w_size_ok;
    logic [2:0]                w_align_bits;
    logic                      w_aligned;
    logic                      w_legal;
    logic [7:0]                w_wr_mask;
    logic [dword_width_gp-1:0] w_wr_data;
    logic [lg_els_lp-1:0]      w_idx;
    logic                      w_ram_v;
    logic [dword_width_gp-1:0] w_ram_rdata;
    logic [dword_width_gp-1:0] w_rd_fmt;

    // FSM / control state
    eth_uc_responder_state_e   r_state;
    logic                      r_cmd_ready;
    logic                      r_resp_v;
    logic [7:0]                r_err_count;

    // Datapath state (not reset; only meaningful while a response is valid)
    bedrock_mem_header_s       r_hdr;
    logic                      r_rd;
    logic [dword_width_gp-1:0] r_data;

    assign w_cmd_hdr  = bedrock_mem_header_s'(mem_cmd_header_i);
    assign w_cmd_fire = mem_cmd_v_i & r_cmd_ready;

    assign w_is_rd    = (w_cmd_hdr.msg_type == e_bedrock_mem_uc_rd);
    assign w_is_wr    = (w_cmd_hdr.msg_type == e_bedrock_mem_uc_wr);
    assign w_in_range = (w_cmd_hdr.addr >= base_addr_p) &&
                        (w_cmd_hdr.addr <  end_addr_lp);

    // Anything wider than a dword cannot be served by this dword RAM.
    assign w_size_ok    = (w_cmd_hdr.size <= e_bedrock_msg_size_8);
    // Low address bits that must be zero for a naturally aligned access.
    assign w_align_bits = 3'((4'd1 << w_cmd_hdr.size[1:0]) - 4'd1);
    assign w_aligned    = ((w_cmd_hdr.addr[2:0] & w_align_bits) == 3'd0);

    assign w_legal = (w_is_rd | w_is_wr) & w_in_range & w_size_ok & w_aligned;

    // Legal accesses are aligned, so the shifted mask never spills past bit 7.
    assign w_wr_mask = size_to_byte_mask(w_cmd_hdr.size) << w_cmd_hdr.addr[2:0];
    assign w_wr_data = replicate_dword(mem_cmd_data_i, w_cmd_hdr.size);
    assign w_idx     = w_cmd_hdr.addr[3 +: lg_els_lp];

    // Gating with reset_i suppresses a write offered in the reset cycle.
    assign w_ram_v   = w_cmd_fire & w_legal & ~reset_i;

    bsg_mem_1rw_sync_mask_write_byte #(
        .data_width_p (dword_width_gp),
        .els_p        (els_p)
    ) ram (
        .clk_i        (clk_i),
        .v_i          (w_ram_v),
        .w_i          (w_is_wr),
        .addr_i       (w_idx),
        .data_i       (w_wr_data),
        .write_mask_i (w_wr_mask),
        .data_o       (w_ram_rdata)
    );

    // Select the requested bytes from the read dword and fan them out.
    assign w_rd_fmt = replicate_dword(w_ram_rdata >> {r_hdr.addr[2:0], 3'b000},
                                      r_hdr.size);

    // ------------------------------------------------------------------
    // Control FSM with registered handshake outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= e_ready;
            r_cmd_ready <= 1'b1;
            r_resp_v    <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            case (r_state)
                e_ready: begin
                    if (w_cmd_fire) begin
                        r_state     <= e_access;
                        r_cmd_ready <= 1'b0;
                        if (!w_legal && (r_err_count != 8'hff)) begin
                            r_err_count <= r_err_count + 8'd1;
                        end
                    end
                end
                e_access: begin
                    r_state  <= e_resp;
                    r_resp_v <= 1'b1;
                end
                e_resp: begin
                    if (mem_resp_ready_and_i) begin
                        r_state     <= e_ready;
                        r_resp_v    <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= e_ready;
                    r_resp_v    <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Header latch and response data register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_cmd_fire) begin
            r_hdr <= w_cmd_hdr;
            r_rd  <= w_legal & w_is_rd;
        end
        if (r_state == e_access) begin
            r_data <= r_rd ? w_rd_fmt : '0;
        end
    end

    assign mem_cmd_ready_and_o = r_cmd_ready;
    assign mem_resp_v_o        = r_resp_v;
    assign mem_resp_header_o   = r_hdr;
    assign mem_resp_data_o     = r_data;
    assign err_count_o         = r_err_count;

endmodule

// File: tb/tb_eth_uc_mem_responder.sv
`timescale 1ns/1ps
module tb_eth_uc_mem_responder;
    import eth_uc_mem_responder_pkg::*;

    localparam logic [39:0] BASE = 40'h0080_3000_00;
    localparam int          ELS  = 8;
    localparam logic [3:0]  T_RD  = e_bedrock_mem_uc_rd;
    localparam logic [3:0]  T_WR  = e_bedrock_mem_uc_wr;
    localparam logic [3:0]  T_CRD = e_bedrock_mem_rd;
    localparam logic [3:0]  T_AMO = e_bedrock_mem_amo;

    logic clk = 1'b0;
    logic reset;
    logic [xce_mem_msg_header_width_lp-1:0] cmd_hdr;
    logic [xce_mem_msg_header_width_lp-1:0] resp_hdr;
    logic [63:0] cmd_data;
    logic [63:0] resp_data;
    logic        cmd_v;
    logic        cmd_ready;
    logic        resp_v;
    logic        resp_ready;
    logic [7:0]  err_count;

    int nvec = 0;
    int nmis = 0;

    // Reference state: RAM image and error count
    logic [63:0] mem_m [ELS];
    int          err_m;

    always #5 clk = ~clk;

    eth_uc_mem_responder #(
        .base_addr_p (BASE),
        .els_p       (ELS)
    ) dut (
        .clk_i                (clk),
        .reset_i              (reset),
        .mem_cmd_header_i     (cmd_hdr),
        .mem_cmd_data_i       (cmd_data),
        .mem_cmd_v_i          (cmd_v),
        .mem_cmd_ready_and_o  (cmd_ready),
        .mem_resp_header_o    (resp_hdr),
        .mem_resp_data_o      (resp_data),
        .mem_resp_v_o         (resp_v),
        .mem_resp_ready_and_i (resp_ready),
        .err_count_o          (err_count)
    );

    typedef struct {
        logic [3:0]  t;
        logic [39:0] a;
        logic [2:0]  s;
        logic [63:0] d;
        logic [63:0] exp_d;
        int          exp_err;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic chkh(input string nm, input bedrock_mem_header_s act, input bedrock_mem_header_s req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    function automatic bedrock_mem_header_s mk(input logic [3:0] t, input logic [39:0] a, input logic [2:0] s);
        bedrock_mem_header_s h;
        h = '0;
        h.msg_type       = t;
        h.addr           = a;
        h.size           = s;
        h.subop          = 4'($urandom);
        h.payload.lce_id = 4'($urandom);
        h.payload.way_id = 3'($urandom);
        return h;
    endfunction

    // Behavioural reference: legality from the address/size rules, then a
    // byte-by-byte write or a byte-by-byte gather of the read result.
    task automatic model(input bedrock_mem_header_s h, input logic [63:0] d, output logic [63:0] r);
        int nb, off, idx;
        bit legal;
        r = '0;
        legal = ((h.msg_type == T_RD) || (h.msg_type == T_WR)) &&
                (h.addr >= BASE) && (h.addr < BASE + 40'(8 * ELS)) &&
                (h.size <= 3'd3) && ((int'(h.addr[5:0]) % (1 << h.size)) == 0);
        if (!legal) begin
            if (err_m < 255) err_m++;
            return;
        end
        nb  = 1 << h.size;
        off = int'(h.addr % 40'd8);
        idx = int'((h.addr - BASE) / 40'd8);
        if (h.msg_type == T_WR) begin
            for (int i = 0; i < nb; i++) mem_m[idx][(off + i) * 8 +: 8] = d[i * 8 +: 8];
        end else begin
            for (int k = 0; k < 8; k++) r[k * 8 +: 8] = mem_m[idx][(off + (k % nb)) * 8 +: 8];
        end
    endtask

    // One full transaction with the response accepted immediately.
    task automatic xact(input bedrock_mem_header_s h, input logic [63:0] d,
                        output logic [63:0] rd, output bedrock_mem_header_s rh, output int lat);
        int n;
        @(negedge clk);
        cmd_hdr = h; cmd_data = d; cmd_v = 1'b1; resp_ready = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 cmd_v = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!resp_v && lat < 10);
        if (n >= 20) lat = 99;
        rd = resp_data;
        rh = bedrock_mem_header_s'(resp_hdr);
        @(posedge clk);
    endtask

    task automatic run_check(input string nm, input bedrock_mem_header_s h, input logic [63:0] d,
                             input logic [63:0] exp_d, input int exp_err);
        logic [63:0] rd;
        bedrock_mem_header_s rh;
        int lat;
        xact(h, d, rd, rh, lat);
        chk({nm, " latency"}, 64'(lat), 64'd2);
        chkh({nm, " header"}, rh, h);
        chk({nm, " data"}, rd, exp_d);
        chk({nm, " err_count"}, 64'(err_count), 64'(exp_err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cmd_v = 1'b0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        err_m = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bedrock_mem_header_s h, h2;
        logic [63:0] e, d;
        logic [39:0] a;
        logic [3:0]  t;
        logic [2:0]  s;
        int          r;
        bit          seen;

        reset = 1'b1; cmd_v = 1'b0; resp_ready = 1'b1;
        cmd_hdr = '0; cmd_data = '0; err_m = 0;

        tbl[0]  = '{T_WR,  BASE + 40'h00, 3'd3, 64'h0000_0000_0000_00ab, 64'h0, 0};
        tbl[1]  = '{T_RD,  BASE + 40'h00, 3'd3, 64'h0,                   64'h0000_0000_0000_00ab, 0};
        tbl[2]  = '{T_WR,  BASE + 40'h08, 3'd3, 64'h1122_3344_5566_7788, 64'h0, 0};
        tbl[3]  = '{T_WR,  BASE + 40'h0B, 3'd0, 64'h0000_0000_0000_005a, 64'h0, 0};
        tbl[4]  = '{T_RD,  BASE + 40'h08, 3'd3, 64'h0,                   64'h1122_3344_5a66_7788, 0};
        tbl[5]  = '{T_RD,  BASE + 40'h0B, 3'd0, 64'h0,                   64'h5a5a_5a5a_5a5a_5a5a, 0};
        tbl[6]  = '{T_RD,  BASE + 40'h02, 3'd2, 64'h0,                   64'h0, 1};
        tbl[7]  = '{T_WR,  BASE + 40'h40, 3'd3, 64'hffff_ffff_ffff_ffff, 64'h0, 2};
        tbl[8]  = '{T_RD,  BASE + 40'h08, 3'd3, 64'h0,                   64'h1122_3344_5a66_7788, 2};
        tbl[9]  = '{T_RD,  BASE + 40'h0A, 3'd1, 64'h0,                   64'h5a66_5a66_5a66_5a66, 2};
        tbl[10] = '{T_CRD, BASE + 40'h00, 3'd3, 64'h0,                   64'h0, 3};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset ready",     64'(cmd_ready), 64'd1);
        chk("reset resp_v",    64'(resp_v),    64'd0);
        chk("reset err_count", 64'(err_count), 64'd0);

        // Directed table
        for (int i = 0; i < 11; i++) begin
            h = mk(tbl[i].t, tbl[i].a, tbl[i].s);
            run_check($sformatf("tbl%0d", i), h, tbl[i].d, tbl[i].exp_d, tbl[i].exp_err);
        end

        // Response backpressure with a second command waiting
        h  = mk(T_RD, BASE, 3'd3);
        h2 = mk(T_WR, BASE + 40'h10, 3'd3);
        @(negedge clk);
        cmd_hdr = h; cmd_data = '0; cmd_v = 1'b1; resp_ready = 1'b0;
        @(posedge clk);
        #1 cmd_hdr = h2; cmd_data = 64'hcafe_f00d_0123_4567;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d resp_v", i), 64'(resp_v), 64'd1);
            chkh($sformatf("bp%0d header", i), bedrock_mem_header_s'(resp_hdr), h);
            chk($sformatf("bp%0d data", i), resp_data, 64'h0000_0000_0000_00ab);
            chk($sformatf("bp%0d ready", i), 64'(cmd_ready), 64'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp after handshake ready",  64'(cmd_ready), 64'd1);
        chk("bp after handshake resp_v", 64'(resp_v),    64'd0);
        @(posedge clk);
        #1 cmd_v = 1'b0;
        @(negedge clk);
        chk("bp second accepted", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        chk("bp second resp_v", 64'(resp_v), 64'd1);
        chkh("bp second header", bedrock_mem_header_s'(resp_hdr), h2);
        chk("bp second data", resp_data, 64'h0);
        @(posedge clk);

        // Randomized phase against the reference model
        do_reset();
        for (int i = 0; i < ELS; i++) begin
            d = {$urandom, $urandom};
            h = mk(T_WR, BASE + 40'(8 * i), 3'd3);
            model(h, d, e);
            run_check($sformatf("preload%0d", i), h, d, e, err_m);
        end

        // A write presented during reset must not reach the RAM
        @(negedge clk);
        reset = 1'b1; cmd_hdr = mk(T_WR, BASE + 40'h18, 3'd3);
        cmd_data = ~mem_m[3]; cmd_v = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; cmd_v = 1'b0;
        h = mk(T_RD, BASE + 40'h18, 3'd3);
        model(h, '0, e);
        run_check("write under reset", h, '0, e, err_m);

        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 9));
            t = (r < 4) ? T_RD : (r < 8) ? T_WR : (r == 8) ? T_CRD : T_AMO;
            s = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a = BASE - 40'(1 + $urandom_range(0, 31));
            else a = BASE + 40'($urandom_range(0, 8 * ELS + 15));
            if ($urandom_range(0, 3) != 0) a = a & ~(40'((1 << s) - 1));
            d = {$urandom, $urandom};
            h = mk(t, a, s);
            model(h, d, e);
            run_check($sformatf("rnd%0d", i), h, d, e, err_m);
        end

        // Reset in the access cycle of a read drops the response
        @(negedge clk);
        cmd_hdr = mk(T_RD, BASE, 3'd3); cmd_v = 1'b1; resp_ready = 1'b1;
        @(posedge clk);
        #1 cmd_v = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        err_m = 0;
        @(negedge clk);
        chk("mid reset ready",     64'(cmd_ready), 64'd1);
        chk("mid reset resp_v",    64'(resp_v),    64'd0);
        chk("mid reset err_count", 64'(err_count), 64'd0);
        seen = 1'b0;
        repeat (5) begin @(negedge clk); if (resp_v) seen = 1'b1; end
        chk("mid reset no response", 64'(seen), 64'd0);

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            h = mk(T_WR, BASE + 40'(8 * ELS) + 40'(8 * (i % 16)), 3'd3);
            model(h, 64'hdead_beef_dead_beef, e);
            run_check($sformatf("sat%0d", i), h, 64'hdead_beef_dead_beef, e, err_m);
        end
        chk("saturated err_count", 64'(err_count), 64'd255);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
